barcode_tx: RTL

Synthesizable barcode transmitter: serializes an 8-bit station ID onto the single-wire `BC` line using the same pulse-width protocol the `barcode` reader decodes. It is the production counterpart of the bench-only mimic. It sits beside the station logic and drives `BC` into the reader, or out to a pad in loopback/self-test builds. One frame is sent per `send` request, and `BC_done` pulses at frame end.

---
 rtl/barcode_pkg.sv | 31 +++
 rtl/barcode_cell_timer.sv | 38 +++
 rtl/barcode_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/barcode_pkg.sv
// Shared constants and types for the single-wire barcode transmitter.
// Optional feature: define BARCODE_PARITY_EN to append an odd-parity cell.
package barcode_pkg;

  localparam int PERIOD_W   = 22;
  localparam int ID_W       = 8;
  localparam int MIN_PERIOD = 16;

  // Low-time fractions of a cell, as right shifts of the period.
  localparam int START_SH = 1;  // start cell: P/2
  localparam int ONE_SH   = 2;  // data 1: P/4 ; data 0: P/2 + P/4

`ifdef BARCODE_PARITY_EN
  localparam int PAR_CELLS = 1;
`else
  localparam int PAR_CELLS = 0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Short periods would collapse the quarter-cell phases, so raise them.
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
    return (p < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : p;
  endfunction

endpackage

// File: rtl/barcode_cell_timer.sv
// Per-cell cycle counter with low-phase and cell-end compares.
module barcode_cell_timer #(
  parameter int PERIOD_W = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cell_start,
  input  logic                run,
  input  logic [PERIOD_W-1:0] low_last,
  input  logic [PERIOD_W-1:0] cell_last,
  output logic                low_end,
  output logic                cell_end
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  // Clear at every cell start, count while a frame is on the wire.
  always_comb begin
    cnt_d = cnt_q;
    if (cell_start)
      cnt_d = '0;
    else if (run)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Thresholds arrive pre-decremented so these fire on the last cycle of a phase.
  assign low_end  = (cnt_q == low_last);
  assign cell_end = (cnt_q == cell_last);

endmodule

// File: rtl/barcode_tx.sv
// Barcode transmitter: start cell + ID_W data cells (MSB first), pulse-width coded.
// Optional feature: BARCODE_PARITY_EN adds an odd-parity cell after the data.
module barcode_tx #(
  parameter int PERIOD_W = barcode_pkg::PERIOD_W,
  parameter int ID_W     = barcode_pkg::ID_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                send,
  input  logic [ID_W-1:0]     station_ID,
  output logic                BC,
  output logic                BC_done,
  output logic                busy
);
  import barcode_pkg::*;

  localparam int N_CELLS = ID_W + 1 + PAR_CELLS;
  localparam int SH_W    = ID_W + PAR_CELLS;
  localparam int CI_W    = $clog2(N_CELLS);

  state_e              state_q, state_d;
  logic                bc_q, bc_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic [CI_W-1:0]     cell_idx_q, cell_idx_d;
  logic [PERIOD_W-1:0] per_last_q, per_last_d;
  logic [PERIOD_W-1:0] lo_start_q, lo_start_d;
  logic [PERIOD_W-1:0] lo_one_q, lo_one_d;
  logic [PERIOD_W-1:0] lo_zero_q, lo_zero_d;

  logic                accept, cell_start, run, low_end, cell_end;
  logic [PERIOD_W-1:0] p_clamp, low_last;
  logic [SH_W-1:0]     sh_load;

  assign p_clamp = clamp_period(period);

`ifdef BARCODE_PARITY_EN
  assign sh_load = {station_ID, ~^station_ID};
`else
  assign sh_load = station_ID;
`endif

  // Low-phase length for the cell in flight: start cell or current data/parity bit.
  assign low_last = (cell_idx_q == '0)   ? lo_start_q :
                    sh_q[SH_W-1]         ? lo_one_q   : lo_zero_q;

  // DONE also accepts so a held send starts the next frame right after the pulse.
  assign accept = send && (state_q == ST_IDLE || state_q == ST_DONE);
  assign run    = (state_q == ST_LOW) || (state_q == ST_HIGH);

  barcode_cell_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .cell_start(cell_start),
    .run       (run),
    .low_last  (low_last),
    .cell_last (per_last_q),
    .low_end   (low_end),
    .cell_end  (cell_end)
  );

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    bc_d       = bc_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    sh_d       = sh_q;
    cell_idx_d = cell_idx_q;
    per_last_d = per_last_q;
    lo_start_d = lo_start_q;
    lo_one_d   = lo_one_q;
    lo_zero_d  = lo_zero_q;
    cell_start = 1'b0;

    unique case (state_q)
      ST_IDLE: ;
      ST_LOW: begin
        if (low_end) begin
          state_d = ST_HIGH;
          bc_d    = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cell_end) begin
          if (cell_idx_q == CI_W'(N_CELLS - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            if (cell_idx_q != '0)
              sh_d = sh_q << 1;
            cell_idx_d = cell_idx_q + 1'b1;
            cell_start = 1'b1;
            state_d    = ST_LOW;
            bc_d       = 1'b0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Latch period-derived thresholds once per frame; all fit in PERIOD_W bits.
    if (accept) begin
      per_last_d = p_clamp - 1'b1;
      lo_start_d = (p_clamp >> START_SH) - 1'b1;
      lo_one_d   = (p_clamp >> ONE_SH) - 1'b1;
      lo_zero_d  = (p_clamp >> START_SH) + (p_clamp >> ONE_SH) - 1'b1;
      sh_d       = sh_load;
      cell_idx_d = '0;
      cell_start = 1'b1;
      state_d    = ST_LOW;
      bc_d       = 1'b0;
      busy_d     = 1'b1;
    end
  end

  // State register; reset forces the line idle and suppresses any done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bc_q       <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      sh_q       <= '0;
      cell_idx_q <= '0;
      per_last_q <= '0;
      lo_start_q <= '0;
      lo_one_q   <= '0;
      lo_zero_q  <= '0;
    end else begin
      state_q    <= state_d;
      bc_q       <= bc_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      sh_q       <= sh_d;
      cell_idx_q <= cell_idx_d;
      per_last_q <= per_last_d;
      lo_start_q <= lo_start_d;
      lo_one_q   <= lo_one_d;
      lo_zero_q  <= lo_zero_d;
    end
  end

  assign BC      = bc_q;
  assign BC_done = done_q;
  assign busy    = busy_q;

endmodule
